// File: rtl/uart8.sv
// uart8: 8N1 full-duplex UART with a 16x oversampled receiver and a bit-period transmitter.
// Receiver and transmitter are independent FSMs that share only clock and reset.
module uart8 #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxEn,
  input  logic       rx,
  output logic [7:0] out,
  output logic       rxDone,
  output logic       rxBusy,
  output logic       rxErr,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);

  localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RX_DW  = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int TX_DW  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam logic [RX_DW-1:0] RX_LAST = RX_DW'(RX_DIV - 1);
  localparam logic [TX_DW-1:0] TX_LAST = TX_DW'(TX_DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

  rxState_t         r_rxState, w_rxNext;
  logic [1:0]       r_rxSync;
  logic             r_rxPrev;
  logic [RX_DW-1:0] r_rxDiv;
  logic [3:0]       r_rxTicks;
  logic [2:0]       r_rxBit;
  logic [7:0]       r_rxShift;
  logic [7:0]       r_out;
  logic             r_rxDone;
  logic             r_rxErr;
  logic             w_rxLine;
  logic             w_rxFall;
  logic             w_rxTick;
  logic             w_rxSample;
  logic             w_rxGood;
  logic             w_rxBad;

  txState_t         r_txState, w_txNext;
  logic [TX_DW-1:0] r_txDiv;
  logic [2:0]       r_txBit;
  logic [7:0]       r_txData;
  logic             r_txDone;
  logic             w_txBitEnd;
  logic             w_txAccept;
  logic             w_txFinish;
  logic             w_tx;

  assign w_rxLine = r_rxSync[1];
  assign w_rxFall = r_rxPrev & ~w_rxLine;
  assign w_rxTick = (r_rxState != RX_IDLE) && (r_rxDiv == RX_LAST);

  // rx is asynchronous to clk; the edge detector only ever sees the synchronized copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxSync <= 2'b11;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxSync <= {r_rxSync[0], rx};
      r_rxPrev <= w_rxLine;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rxState <= RX_IDLE;
    else     r_rxState <= w_rxNext;
  end

  always_comb begin
    w_rxNext   = r_rxState;
    w_rxSample = 1'b0;
    w_rxGood   = 1'b0;
    w_rxBad    = 1'b0;
    case (r_rxState)
      RX_IDLE:  if (w_rxFall) w_rxNext = RX_START;
      RX_START: if (w_rxTick && r_rxTicks == 4'd7) w_rxNext = w_rxLine ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (w_rxTick && r_rxTicks == 4'd15) begin
          w_rxSample = 1'b1;
          if (r_rxBit == 3'd7) w_rxNext = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_rxTick && r_rxTicks == 4'd15) begin
          w_rxNext = RX_IDLE;
          w_rxGood = w_rxLine;
          w_rxBad  = ~w_rxLine;
        end
      end
      default: w_rxNext = RX_IDLE;
    endcase
    if (!rxEn) begin
      w_rxNext   = RX_IDLE;
      w_rxSample = 1'b0;
      w_rxGood   = 1'b0;
      w_rxBad    = 1'b0;
    end
  end

  // Idle holds the divider and tick count at zero, so every frame starts from a clean phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxDiv   <= '0;
      r_rxTicks <= 4'd0;
      r_rxBit   <= 3'd0;
      r_rxShift <= 8'h00;
      r_out     <= 8'h00;
      r_rxDone  <= 1'b0;
      r_rxErr   <= 1'b0;
    end else begin
      r_rxDiv <= (r_rxState == RX_IDLE || w_rxTick) ? '0 : r_rxDiv + 1'b1;
      if (r_rxState == RX_IDLE)
        r_rxTicks <= 4'd0;
      else if (w_rxTick)
        r_rxTicks <= (r_rxState == RX_START && r_rxTicks == 4'd7) ? 4'd0 : r_rxTicks + 4'd1;
      if (r_rxState != RX_DATA) r_rxBit <= 3'd0;
      else if (w_rxSample)      r_rxBit <= r_rxBit + 3'd1;
      if (w_rxSample) r_rxShift <= {w_rxLine, r_rxShift[7:1]};
      if (w_rxGood)   r_out     <= r_rxShift;
      r_rxDone <= w_rxGood;
      r_rxErr  <= w_rxBad;
    end
  end

  assign out    = r_out;
  assign rxDone = r_rxDone;
  assign rxErr  = r_rxErr;
  assign rxBusy = (r_rxState != RX_IDLE);

  assign w_txBitEnd = (r_txDiv == TX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_txState <= TX_IDLE;
    else     r_txState <= w_txNext;
  end

  // Accepting in IDLE also covers the txDone cycle, which gives back-to-back frames
  always_comb begin
    w_txNext   = r_txState;
    w_txAccept = 1'b0;
    w_txFinish = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        if (txStart) begin
          w_txAccept = 1'b1;
          w_txNext   = TX_START;
        end
      end
      TX_START: if (w_txBitEnd) w_txNext = TX_DATA;
      TX_DATA:  if (w_txBitEnd && r_txBit == 3'd7) w_txNext = TX_STOP;
      TX_STOP: begin
        if (w_txBitEnd) begin
          w_txNext   = TX_IDLE;
          w_txFinish = 1'b1;
        end
      end
      default: w_txNext = TX_IDLE;
    endcase
    if (!txEn) begin
      w_txNext   = TX_IDLE;
      w_txAccept = 1'b0;
      w_txFinish = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txDiv  <= '0;
      r_txBit  <= 3'd0;
      r_txData <= 8'h00;
      r_txDone <= 1'b0;
    end else begin
      r_txDiv <= (r_txState == TX_IDLE || w_txBitEnd) ? '0 : r_txDiv + 1'b1;
      if (r_txState != TX_DATA) r_txBit <= 3'd0;
      else if (w_txBitEnd)      r_txBit <= r_txBit + 3'd1;
      if (w_txAccept) r_txData <= in;
      r_txDone <= w_txFinish;
    end
  end

  always_comb begin
    w_tx = 1'b1;
    case (r_txState)
      TX_START: w_tx = 1'b0;
      TX_DATA:  w_tx = r_txData[r_txBit];
      default:  w_tx = 1'b1;
    endcase
  end

  assign tx     = w_tx;
  assign txBusy = (r_txState != TX_IDLE);
  assign txDone = r_txDone;

endmodule

// File: tb/tb_uart8.sv
// tb_uart8: randomized scoreboard bench for uart8 at 16 clks per bit (RX_DIV=1, TX_DIV=16).
// Drivers push expected receive events and transmit frames; independent monitors pop and compare.
module tb_uart8;

  localparam int CR       = 16000;
  localparam int BR       = 1000;
  localparam int BIT_CLKS = 16;

  typedef struct {
    bit         isErr;
    logic [7:0] data;
    int         startCyc;
  } rxExp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxEn = 1'b0;
  logic       rxDrv = 1'b1;
  logic       loopMode = 1'b0;
  logic       txEn = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] inByte = 8'h00;
  logic [7:0] out;
  logic       rxDone, rxBusy, rxErr, txBusy, txDone, tx, rxLine;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         txMonOn = 1'b1;
  logic [7:0] lastGood = 8'h00;
  rxExp_t     rxQ[$];
  logic [7:0] txQ[$];

  assign rxLine = loopMode ? tx : rxDrv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart8 #(.CLOCK_RATE(CR), .BAUD_RATE(BR)) dut (
    .clk(clk), .rst(rst), .rxEn(rxEn), .rx(rxLine), .out(out),
    .rxDone(rxDone), .rxBusy(rxBusy), .rxErr(rxErr),
    .txEn(txEn), .txStart(txStart), .in(inByte),
    .txBusy(txBusy), .txDone(txDone), .tx(tx)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference line level of a frame k clocks after its start: start 0, d0..d7, stop 1
  function automatic logic expectedTxBit(input logic [7:0] d, input int k);
    int idx;
    idx = k / BIT_CLKS;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  task automatic sendRxFrame(input logic [7:0] data, input logic stopBit, input bit scored);
    rxExp_t     e;
    logic [9:0] bits;
    bits = {stopBit, data, 1'b0};
    @(posedge clk); #1;
    if (scored) begin
      if (stopBit) lastGood = data;
      e.isErr    = !stopBit;
      e.data     = lastGood;
      e.startCyc = cyc;
      rxQ.push_back(e);
    end
    for (int b = 0; b < 10; b++) begin
      rxDrv = bits[b];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    rxDrv = 1'b1;
  endtask

  task automatic sendTxByte(input logic [7:0] data, input bit poke);
    int w;
    @(posedge clk); #1;
    inByte  = data;
    txStart = 1'b1;
    txQ.push_back(data);
    @(posedge clk); #1;
    txStart = 1'b0;
    @(negedge clk);
    checkOutput("txAcceptBusy", txBusy, 1);
    checkOutput("txAcceptLine", tx, 0);
    if (poke) begin
      repeat ($urandom_range(10, 130)) @(posedge clk);
      #1;
      inByte  = ~data;
      txStart = 1'b1;
      @(posedge clk); #1;
      txStart = 1'b0;
    end
    w = 0;
    while (!txDone && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput("txDoneSeen", txDone, 1);
  endtask

  initial begin : rxMon
    rxExp_t e;
    int     lat;
    forever begin
      @(negedge clk);
      if (!rst && (rxDone || rxErr)) begin
        if (rxQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rxUnexpected: got rxDone=%0b rxErr=%0b, required no event", rxDone, rxErr);
        end else begin
          e = rxQ.pop_front();
          checkOutput("rxKind", {30'b0, rxDone, rxErr}, e.isErr ? 32'd1 : 32'd2);
          checkOutput("rxOut", out, e.data);
          if (e.startCyc >= 0) begin
            lat = cyc - e.startCyc;
            total++;
            if (lat < 150 || lat > 160) begin
              bad++;
              $display("[TB] FAIL rxLatency: got %0d clks, required 150..160", lat);
            end
          end
        end
      end
    end
  end

  initial begin : txMon
    logic       prevBusy;
    logic [7:0] d;
    int         waveBad, busyBad, firstBad;
    prevBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && txMonOn && txBusy && !prevBusy) begin
        if (txQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL txUnexpected: got a frame start, required none");
          prevBusy = txBusy;
        end else begin
          d        = txQ.pop_front();
          waveBad  = 0;
          busyBad  = 0;
          firstBad = -1;
          for (int k = 0; k < 10 * BIT_CLKS; k++) begin
            if (k > 0) @(negedge clk);
            if (tx !== expectedTxBit(d, k)) begin
              waveBad++;
              if (firstBad < 0) firstBad = k;
            end
            if (txBusy !== 1'b1 || txDone !== 1'b0) busyBad++;
          end
          if (waveBad != 0) $display("[TB] byte 0x%0h first wrong tx at clk %0d", d, firstBad);
          checkOutput("txWave", waveBad, 0);
          checkOutput("txBusyFrame", busyBad, 0);
          @(negedge clk);
          checkOutput("txDoneEnd", {30'b0, txDone, txBusy}, 32'd2);
          prevBusy = txBusy;
        end
      end else begin
        prevBusy = txBusy;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus();
    int w;
    int cnt;

    @(negedge clk);
    checkOutput("rstTx", tx, 1);
    checkOutput("rstOut", out, 0);
    checkOutput("rstFlags", {27'b0, txBusy, txDone, rxBusy, rxDone, rxErr}, 0);
    @(posedge clk); #1;
    rst  = 1'b0;
    rxEn = 1'b1;
    txEn = 1'b1;
    repeat (4) @(posedge clk);

    sendRxFrame(8'h55, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    sendRxFrame(8'hA3, 1'b0, 1'b1);
    repeat (5) @(posedge clk);

    @(posedge clk); #1;
    rxDrv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxDrv = 1'b1;
    @(negedge clk);
    checkOutput("glitchBusy", rxBusy, 1);
    w = 0;
    while (rxBusy && w < 10) begin
      @(negedge clk);
      w++;
    end
    checkOutput("glitchIdle", rxBusy, 0);

    sendTxByte(8'hC4, 1'b0);
    repeat (3) @(posedge clk);

    // Loopback: txStart stays high so the second byte is taken in the txDone cycle
    loopMode = 1'b1;
    begin
      rxExp_t e;
      e.isErr = 1'b0; e.data = 8'h00; e.startCyc = -1; rxQ.push_back(e);
      e.data = 8'hFF; rxQ.push_back(e);
      lastGood = 8'hFF;
    end
    @(posedge clk); #1;
    inByte  = 8'h00;
    txStart = 1'b1;
    txQ.push_back(8'h00);
    txQ.push_back(8'hFF);
    w = 0;
    while (!txBusy && w < 5) begin
      @(negedge clk);
      w++;
    end
    checkOutput("loopFirstAccept", txBusy, 1);
    @(posedge clk); #1;
    inByte = 8'hFF;
    w = 0;
    while (!txDone && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput("loopFirstDone", txDone, 1);
    @(posedge clk); #1;
    txStart = 1'b0;
    @(negedge clk);
    checkOutput("loopSecondAccept", txBusy, 1);
    w = 0;
    while (!txDone && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput("loopSecondDone", txDone, 1);
    w = 0;
    while (rxQ.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    checkOutput("loopRxDrained", rxQ.size(), 0);
    @(posedge clk); #1;
    loopMode = 1'b0;
    repeat (4) @(posedge clk);

    fork
      sendRxFrame(8'h3C, 1'b1, 1'b0);
      begin
        repeat (60) @(negedge clk);
        checkOutput("rxAbortPre", rxBusy, 1);
        @(posedge clk); #1;
        rxEn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rxAbortBusy", rxBusy, 0);
      end
    join
    repeat (5) @(posedge clk);
    checkOutput("rxAbortOut", out, lastGood);
    #1;
    rxEn = 1'b1;

    txMonOn = 1'b0;
    @(posedge clk); #1;
    inByte  = 8'h00;
    txStart = 1'b1;
    @(posedge clk); #1;
    txStart = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("txEnPreLine", {31'b0, tx}, 0);
    @(posedge clk); #1;
    txEn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("txEnOffLine", {30'b0, tx, txBusy}, 32'd2);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txDone) cnt++;
    end
    checkOutput("txEnNoDone", cnt, 0);
    @(posedge clk); #1;
    txEn = 1'b1;

    @(posedge clk); #1;
    inByte  = 8'h00;
    txStart = 1'b1;
    @(posedge clk); #1;
    txStart = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("rstPreLine", {31'b0, tx}, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstMidTx", tx, 1);
    checkOutput("rstMidFlags", {27'b0, txBusy, txDone, rxBusy, rxDone, rxErr}, 0);
    checkOutput("rstMidOut", out, 0);
    lastGood = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    txMonOn = 1'b1;
    repeat (4) @(posedge clk);

    fork
      begin
        for (int i = 0; i < 5; i++) begin
          sendRxFrame(8'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
          repeat ($urandom_range(2, 10)) @(posedge clk);
        end
      end
      begin
        for (int i = 0; i < 5; i++) begin
          sendTxByte(8'($urandom), 1'b1);
          repeat ($urandom_range(0, 6)) @(posedge clk);
        end
      end
    join
    repeat (20) @(posedge clk);
  endtask

  initial begin : mainSeq
    applyStimulus();
    checkOutput("rxQueueEmpty", rxQ.size(), 0);
    checkOutput("txQueueEmpty", txQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
